alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Time-multiplexes one external combinational ALU between N requesters, such as the execute stage and a compression helper unit. Each requester uses a valid/ready request channel and a valid/ready response channel. Requesters are served one at a time under round-robin or fixed priority. The block sits between the requesters and the ALU, driving its operands and 4-bit control code from registers and capturing the result.

## Interface
- `WIDTH`, 32: operand/result width.
- `N`, 2: number of requesters (2..8).
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  N  request valid per requester.
- `req_ready_o`  out  N  request accepted (at most one bit set).
- `req_data1_i`  in  N*WIDTH  operand 1; requester k at bits [k*WIDTH +: WIDTH].
- `req_data2_i`  in  N*WIDTH  operand 2, same packing.
- `req_ctrl_i`  in  4*N  ALU control code; requester k at [4k +: 4].
- `rsp_valid_o`  out  N  response valid, one-hot to the owner.
- `rsp_ready_i`  in  N  response consumed.
- `rsp_data_o`  out  WIDTH  result, shared by all requesters.
- `rsp_err_o`  out  1  control code was illegal and was replaced by ADD.
- `alu_data1_o`, `alu_data2_o`  out  WIDTH  ALU operands (registered).
- `alu_ctrl_o`  out  4  ALU control (registered).
- `alu_result_i`  in  WIDTH  combinational ALU result.
- `busy_o`  out  1  high whenever state is not IDLE.

## Operation
- State machine: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - Arbitrate among the set bits of `req_valid_i`.
  - `req_ready_o` is the one-hot grant, driven combinationally and only in IDLE.
  - On `req_valid_i[g] & req_ready_o[g]`: latch data1, data2, ctrl and owner g, then go to ISSUE.
- Legal control codes: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0011 XOR, 1000 SLT, 1001 SLL, 1010 SRL, 1011 SRA.
  - Any other code is latched as 0010, and an error flag is set for this transaction.
- ISSUE:
  - `alu_*_o` present the latched values.
  - At the end of the cycle, capture `alu_result_i` into `rsp_data_o` and go to RESP.
- RESP:
  - `rsp_valid_o[owner]=1`; `rsp_data_o` and `rsp_err_o` are held stable.
  - On `rsp_ready_i[owner]`, go to IDLE.
  - `rsp_ready_i` bits of non-owners are ignored.
- Round-robin pointer `ptr`:
  - Search starts at `ptr` and proceeds upward modulo N.
  - On accept, `ptr <= (g+1) mod N`.
- A requester may drop `req_valid_i` before it is granted; no lock is held.
- Operands are sampled only at the handshake.
- `alu_*_o` keep their last values outside ISSUE.

## Timing
- Reset, and the value of every output during reset:
  - State IDLE, `ptr=0`.
  - `alu_data1_o`/`alu_data2_o`/`rsp_data_o` = 0, `alu_ctrl_o` = 4'b0010.
  - `rsp_valid_o` = 0, `rsp_err_o` = 0, `busy_o` = 0.
  - `req_ready_o` follows the IDLE arbitration as soon as reset is released.
- Latency: accept at edge T; ALU driven during cycle T+1; `rsp_valid_o` high from T+2.
- Minimum initiation interval is 3 cycles: the earliest next accept is the cycle after the response handshake.
- `req_ready_o` is 0 in ISSUE and RESP, including the cycle in which the response completes.
- Response backpressure: RESP is held indefinitely; no new request is accepted while it is held.
- Reset mid-transaction: the transaction is aborted and no `rsp_valid_o` is issued for it.
- All requesters asserting valid at once: exactly one grant per IDLE cycle.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined: the lowest-index valid requester always wins, and `ptr` is neither implemented nor updated.
- Not defined: round-robin as described in Operation.

## Test plan
- Single ADD: requester 0 sends data1=5, data2=7, ctrl=0010.
  - `req_ready_o=01` at T.
  - `alu_ctrl_o=0010` at T+1.
  - At T+2: `rsp_valid_o=01`, `rsp_data_o=12`, `rsp_err_o=0`.
- Contention, round-robin: both requesters hold valid for 4 transactions with `rsp_ready_i` always high.
  - Grants go 0,1,0,1; accepts occur every 3 cycles.
- Fixed priority: same stimulus with `ALU_ARB_FIXED_PRIO_EN` defined.
  - All 4 grants go to requester 0.
- Illegal code: requester 1 sends ctrl=1111, data1=3, data2=4.
  - `alu_ctrl_o=0010`, `rsp_data_o=7`, `rsp_err_o=1`.
- Backpressure: `rsp_ready_i[0]=0` for 5 cycles while requester 1 is valid.
  - `rsp_valid_o=01` and `rsp_data_o` stay stable.
  - `req_ready_o=00` throughout.
  - Requester 1 is accepted one cycle after `rsp_ready_i[0]` rises.
- Reset in ISSUE: assert `rst_i=0` for one cycle.
  - All outputs take their reset values immediately.
  - No `rsp_valid_o` appears afterwards.
  - A new request is accepted normally after reset is released.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU among N valid/ready requesters.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module alu_share_arbiter #(
   parameter int WIDTH = 32,
   parameter int N     = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [N-1:0]         req_valid_i,
   output logic [N-1:0]         req_ready_o,
   input  logic [N*WIDTH-1:0]   req_data1_i,
   input  logic [N*WIDTH-1:0]   req_data2_i,
   input  logic [4*N-1:0]       req_ctrl_i,
   output logic [N-1:0]         rsp_valid_o,
   input  logic [N-1:0]         rsp_ready_i,
   output logic [WIDTH-1:0]     rsp_data_o,
   output logic                 rsp_err_o,
   output logic [WIDTH-1:0]     alu_data1_o,
   output logic [WIDTH-1:0]     alu_data2_o,
   output logic [3:0]           alu_ctrl_o,
   input  logic [WIDTH-1:0]     alu_result_i,
   output logic                 busy_o
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam logic [3:0] CTRL_ADD = 4'b0010;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t           state_reg, state_next;
   logic [PW-1:0]    owner_reg;
   logic             err_pend_reg;
   logic [PW-1:0]    grant_idx;
   logic             grant_any;
   logic             accept;

   logic [WIDTH-1:0] data1_arr [N];
   logic [WIDTH-1:0] data2_arr [N];
   logic [3:0]       ctrl_arr  [N];

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_unpack
         assign data1_arr[gi] = req_data1_i[gi*WIDTH +: WIDTH];
         assign data2_arr[gi] = req_data2_i[gi*WIDTH +: WIDTH];
         assign ctrl_arr[gi]  = req_ctrl_i[gi*4 +: 4];
      end
   endgenerate

   function automatic logic ctrl_legal(input logic [3:0] c);
      case (c)
         4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011,
         4'b1000, 4'b1001, 4'b1010, 4'b1011: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

`ifdef ALU_ARB_FIXED_PRIO_EN
   // Downward scan so the lowest valid index is the last (winning) assignment.
   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_valid_i[i]) begin
            grant_idx = PW'(i);
            grant_any = 1'b1;
         end
      end
   end
`else
   logic [PW-1:0] ptr_reg;
   int            rr_idx;

   // Downward scan over offsets from ptr so the nearest requester at/after ptr wins.
   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      rr_idx    = 0;
      for (int i = N - 1; i >= 0; i--) begin
         rr_idx = int'(ptr_reg) + i;
         if (rr_idx >= N) rr_idx = rr_idx - N;
         if (req_valid_i[rr_idx]) begin
            grant_idx = PW'(rr_idx);
            grant_any = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ptr_reg <= '0;
      end else if (accept) begin
         ptr_reg <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
      end
   end
`endif

   assign accept = (state_reg == IDLE) && grant_any;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (grant_any) state_next = ISSUE;
         ISSUE:   state_next = RESP;
         RESP:    if (rsp_ready_i[owner_reg]) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = '0;
      rsp_valid_o = '0;
      busy_o      = (state_reg != IDLE);
      case (state_reg)
         IDLE:    if (grant_any) req_ready_o[grant_idx] = 1'b1;
         RESP:    rsp_valid_o[owner_reg] = 1'b1;
         default: ;
      endcase
   end

   // Operands drive the ALU straight from these registers; they hold until the next accept.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         alu_data1_o  <= '0;
         alu_data2_o  <= '0;
         alu_ctrl_o   <= CTRL_ADD;
         owner_reg    <= '0;
         err_pend_reg <= 1'b0;
         rsp_data_o   <= '0;
         rsp_err_o    <= 1'b0;
      end else begin
         if (accept) begin
            alu_data1_o  <= data1_arr[grant_idx];
            alu_data2_o  <= data2_arr[grant_idx];
            alu_ctrl_o   <= ctrl_legal(ctrl_arr[grant_idx]) ? ctrl_arr[grant_idx] : CTRL_ADD;
            err_pend_reg <= !ctrl_legal(ctrl_arr[grant_idx]);
            owner_reg    <= grant_idx;
         end
         if (state_reg == ISSUE) begin
            rsp_data_o <= alu_result_i;
            rsp_err_o  <= err_pend_reg;
         end
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter against a transaction-level model.
// Expected grants follow ALU_ARB_FIXED_PRIO_EN when it is defined for the build.
module tb_alu_share_arbiter;

   localparam int WIDTH = 32;
   localparam int N     = 2;

   logic                 clk_i = 1'b0;
   logic                 rst_i;
   logic [N-1:0]         req_valid_i;
   logic [N-1:0]         req_ready_o;
   logic [N*WIDTH-1:0]   req_data1_i;
   logic [N*WIDTH-1:0]   req_data2_i;
   logic [4*N-1:0]       req_ctrl_i;
   logic [N-1:0]         rsp_valid_o;
   logic [N-1:0]         rsp_ready_i;
   logic [WIDTH-1:0]     rsp_data_o;
   logic                 rsp_err_o;
   logic [WIDTH-1:0]     alu_data1_o;
   logic [WIDTH-1:0]     alu_data2_o;
   logic [3:0]           alu_ctrl_o;
   logic [WIDTH-1:0]     alu_result_i;
   logic                 busy_o;

   int vectors     = 0;
   int miscompares = 0;
   int ptr_m       = 0;

   logic [WIDTH-1:0] op_a [N];
   logic [WIDTH-1:0] op_b [N];
   logic [3:0]       op_c [N];

   alu_share_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_data1_i  (req_data1_i),
      .req_data2_i  (req_data2_i),
      .req_ctrl_i   (req_ctrl_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_data_o   (rsp_data_o),
      .rsp_err_o    (rsp_err_o),
      .alu_data1_o  (alu_data1_o),
      .alu_data2_o  (alu_data2_o),
      .alu_ctrl_o   (alu_ctrl_o),
      .alu_result_i (alu_result_i),
      .busy_o       (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // External ALU; unknown codes give a marker value so an unsanitised code is visible.
   function automatic logic [WIDTH-1:0] alu_fn(input logic [3:0] c, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      case (c)
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0011: return a ^ b;
         4'b1000: return ($signed(a) < $signed(b)) ? 1 : 0;
         4'b1001: return a << b[4:0];
         4'b1010: return a >> b[4:0];
         4'b1011: return $signed(a) >>> b[4:0];
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   assign alu_result_i = alu_fn(alu_ctrl_o, alu_data1_o, alu_data2_o);

   function automatic bit is_legal(input logic [3:0] c);
      return c inside {4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011,
                       4'b1000, 4'b1001, 4'b1010, 4'b1011};
   endfunction

   function automatic int pick(input logic [N-1:0] mask);
`ifdef ALU_ARB_FIXED_PRIO_EN
      for (int k = 0; k < N; k++) if (mask[k]) return k;
`else
      for (int off = 0; off < N; off++) if (mask[(ptr_m + off) % N]) return (ptr_m + off) % N;
`endif
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_ops();
      for (int k = 0; k < N; k++) begin
         req_data1_i[k*WIDTH +: WIDTH] = op_a[k];
         req_data2_i[k*WIDTH +: WIDTH] = op_b[k];
         req_ctrl_i[k*4 +: 4]          = op_c[k];
      end
   endtask

   // One full transaction; entered at posedge+1 with the DUT idle.
   task automatic txn(input logic [N-1:0] mask, input logic [N-1:0] post_mask, input int hold);
      int               g;
      logic [3:0]       eff;
      logic [WIDTH-1:0] exp_d;
      logic             exp_e;
      logic [N-1:0]     onehot;
      g      = pick(mask);
      onehot = '0;
      onehot[g] = 1'b1;
      exp_e  = !is_legal(op_c[g]);
      eff    = exp_e ? 4'b0010 : op_c[g];
      exp_d  = alu_fn(eff, op_a[g], op_b[g]);
      drive_ops();
      req_valid_i = mask;
      #1;
      chk("grant", 64'(req_ready_o), 64'(onehot));
      chk("busy_idle", 64'(busy_o), 64'd0);
      @(posedge clk_i); #1;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_m = (g + 1) % N;
`endif
      req_data1_i = {$urandom, $urandom};
      req_data2_i = {$urandom, $urandom};
      req_ctrl_i  = 8'($urandom);
      req_valid_i = post_mask;
      #1;
      chk("issue_busy", 64'(busy_o), 64'd1);
      chk("issue_ready", 64'(req_ready_o), 64'd0);
      chk("issue_rspv", 64'(rsp_valid_o), 64'd0);
      chk("alu_data1", 64'(alu_data1_o), 64'(op_a[g]));
      chk("alu_data2", 64'(alu_data2_o), 64'(op_b[g]));
      chk("alu_ctrl", 64'(alu_ctrl_o), 64'(eff));
      @(posedge clk_i); #1;
      rsp_ready_i = N'($urandom) & ~onehot;
      #1;
      chk("rsp_valid", 64'(rsp_valid_o), 64'(onehot));
      chk("rsp_data", 64'(rsp_data_o), 64'(exp_d));
      chk("rsp_err", 64'(rsp_err_o), 64'(exp_e));
      chk("resp_ready", 64'(req_ready_o), 64'd0);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk_i); #1;
         rsp_ready_i = N'($urandom) & ~onehot;
         #1;
         chk("hold_valid", 64'(rsp_valid_o), 64'(onehot));
         chk("hold_data", 64'(rsp_data_o), 64'(exp_d));
         chk("hold_err", 64'(rsp_err_o), 64'(exp_e));
         chk("hold_ready", 64'(req_ready_o), 64'd0);
      end
      rsp_ready_i = N'($urandom) | onehot;
      #1;
      chk("done_ready", 64'(req_ready_o), 64'd0);
      @(posedge clk_i); #1;
      rsp_ready_i = '0;
      chk("post_rspv", 64'(rsp_valid_o), 64'd0);
      chk("post_busy", 64'(busy_o), 64'd0);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_busy"}, 64'(busy_o), 64'd0);
      chk({tag, "_rspv"}, 64'(rsp_valid_o), 64'd0);
      chk({tag, "_err"}, 64'(rsp_err_o), 64'd0);
      chk({tag, "_rspd"}, 64'(rsp_data_o), 64'd0);
      chk({tag, "_d1"}, 64'(alu_data1_o), 64'd0);
      chk({tag, "_d2"}, 64'(alu_data2_o), 64'd0);
      chk({tag, "_ctrl"}, 64'(alu_ctrl_o), 64'h2);
   endtask

   task automatic set_op(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [3:0] c);
      op_a[k] = a;
      op_b[k] = b;
      op_c[k] = c;
   endtask

   task automatic rand_ops();
      logic [3:0] legal_list [9];
      legal_list = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011,
                     4'b1000, 4'b1001, 4'b1010, 4'b1011};
      for (int k = 0; k < N; k++) begin
         op_a[k] = $urandom;
         op_b[k] = $urandom;
         op_c[k] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal_list[$urandom_range(0, 8)];
      end
   endtask

   initial begin
      rst_i       = 1'b0;
      req_valid_i = '0;
      rsp_ready_i = '0;
      req_data1_i = '0;
      req_data2_i = '0;
      req_ctrl_i  = '0;
      for (int k = 0; k < N; k++) set_op(k, 0, 0, 4'b0010);
      repeat (2) @(posedge clk_i);
      #1;
      chk_reset_values("reset");
      chk("reset_ready", 64'(req_ready_o), 64'd0);
      rst_i = 1'b1;

      // Single ADD from requester 0.
      set_op(0, 5, 7, 4'b0010);
      txn(2'b01, 2'b00, 0);

      // Reset while in ISSUE aborts the transaction.
      set_op(1, 32'h55, 32'h66, 4'b0110);
      drive_ops();
      req_valid_i = 2'b10;
      @(posedge clk_i); #1;
      rst_i       = 1'b0;
      req_valid_i = '0;
      #1;
      chk_reset_values("midrst");
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      ptr_m = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk_i); #1;
         chk("norsp_after_rst", 64'(rsp_valid_o), 64'd0);
      end
      set_op(1, 9, 4, 4'b0110);
      txn(2'b10, 2'b00, 0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      ptr_m = 0;

      // Contention with both requesters valid throughout.
      for (int t = 0; t < 4; t++) begin
         rand_ops();
         txn(2'b11, 2'b11, 0);
      end

      // Illegal control code is replaced by ADD and flagged.
      set_op(1, 3, 4, 4'b1111);
      txn(2'b10, 2'b00, 0);

      // Backpressure on requester 0 while requester 1 waits.
      set_op(0, 32'h1000, 32'h0234, 4'b0001);
      set_op(1, 32'hFFFF_FFF0, 4, 4'b1011);
      txn(2'b01, 2'b11, 5);
      txn(2'b11, 2'b00, 0);

      // Randomized traffic.
      for (int t = 0; t < 40; t++) begin
         rand_ops();
         txn(N'($urandom_range(1, 3)), N'($urandom), $urandom_range(0, 3));
      end

      req_valid_i = '0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
